// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the serial ripple-borrow subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SLICE_W = 2;

   // Counter width for n steps; never narrower than one bit.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/two_bit_rcs.sv
// Combinational 2-bit ripple-borrow subtractor: d = a - b - bin, built from two full subtractors.
module two_bit_rcs
   import serial_sub_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               bin,
   output logic [SLICE_W-1:0] d,
   output logic               bout
);

   logic w_b0;

   assign d[0] = a[0] ^ b[0] ^ bin;
   assign w_b0 = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & bin);

   assign d[1] = a[1] ^ b[1] ^ w_b0;
   assign bout = (~a[1] & b[1]) | (~(a[1] ^ b[1]) & w_b0);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: DIFF = A - B - bin, two bits per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
   output logic             ovf,
`endif
   output logic             bout
);

   localparam int STEPS = WIDTH / 2;
   localparam int CW    = clog2(STEPS);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic             r_bout;
   logic             r_out_valid;
   logic             r_in_ready;

   logic [SLICE_W-1:0] w_d;
   logic               w_bo;
   logic [WIDTH-1:0]   w_res_next;

   two_bit_rcs u_slice (
      .a    (r_a[SLICE_W-1:0]),
      .b    (r_b[SLICE_W-1:0]),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_bo)
   );

   // New slice result enters at the top; after STEPS shifts bit 0 lands at the LSB.
   always_comb begin
      w_res_next = r_res >> SLICE_W;
      w_res_next[WIDTH-1 -: SLICE_W] = w_d;
   end

`ifdef SERIAL_SUB_OVERFLOW_EN
   logic r_a_msb;
   logic r_b_msb;
   logic r_ovf;
   assign ovf = r_ovf;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_res       <= '0;
         r_diff      <= '0;
         r_borrow    <= 1'b0;
         r_cnt       <= '0;
         r_bout      <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
         r_a_msb     <= 1'b0;
         r_b_msb     <= 1'b0;
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_borrow   <= bin;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  r_a_msb    <= a[WIDTH-1];
                  r_b_msb    <= b[WIDTH-1];
`endif
               end
            end
            RUN: begin
               r_a      <= r_a >> SLICE_W;
               r_b      <= r_b >> SLICE_W;
               r_borrow <= w_bo;
               r_res    <= w_res_next;
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_diff      <= w_res_next;
                  r_bout      <= w_bo;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  r_ovf <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign diff      = r_diff;
   assign bout      = r_bout;

endmodule
